// File: rtl/hyper_twd_burst_splitter_pkg.sv
// Shared types and default widths for the hyperbus 1D/2D burst splitter.
// Holds the FSM state enum, the chunk record and the idle transaction ID.
package hyper_splitter_pkg;

    localparam int DEF_L2_AWIDTH      = 12;
    localparam int DEF_EXT_AWIDTH     = 32;
    localparam int DEF_TRANS_SIZE     = 16;
    localparam int DEF_ID_WIDTH       = 1;
    localparam int DEF_MAX_BURST_LOG2 = 9;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } split_state_e;

    typedef struct packed {
        logic [DEF_L2_AWIDTH-1:0]  l2_addr;
        logic [DEF_EXT_AWIDTH-1:0] ext_addr;
        logic [DEF_TRANS_SIZE-1:0] size;
        logic                      rw;
        logic [DEF_ID_WIDTH-1:0]   id;
        logic                      last;
    } chunk_req_t;

    // Upper bit set marks "no transaction in flight" on dst_trans_id_o.
    localparam logic [DEF_ID_WIDTH:0] IDLE_ID = {1'b1, {DEF_ID_WIDTH{1'b0}}};

endpackage

// File: rtl/hyper_twd_burst_splitter_if.sv
// Request/chunk bus of the burst splitter; the splitter uses the slave
// modport, the uDMA side and the hyperbus FSM together form the master.
interface hyper_twd_burst_splitter_if #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int EXT_AWIDTH     = 32,
    parameter int TRANS_SIZE     = 16,
    parameter int ID_WIDTH       = 1
);
    logic                      src_valid_i;
    logic                      src_ready_o;
    logic                      rw_i;
    logic [L2_AWIDTH_NOAL-1:0] l2_addr_i;
    logic [EXT_AWIDTH-1:0]     ext_addr_i;
    logic [TRANS_SIZE-1:0]     size_i;
    logic [ID_WIDTH-1:0]       trans_id_i;
    logic                      ext_act_i;
    logic                      l2_act_i;
    logic [TRANS_SIZE-1:0]     ext_count_i;
    logic [TRANS_SIZE-1:0]     l2_count_i;
    logic [TRANS_SIZE-1:0]     ext_stride_i;
    logic [TRANS_SIZE-1:0]     l2_stride_i;
    logic                      abort_i;

    logic                      dst_valid_o;
    logic                      dst_ready_i;
    logic                      dst_rw_o;
    logic [L2_AWIDTH_NOAL-1:0] dst_l2_addr_o;
    logic [EXT_AWIDTH-1:0]     dst_ext_addr_o;
    logic [TRANS_SIZE-1:0]     dst_size_o;
    logic [ID_WIDTH:0]         dst_trans_id_o;
    logic                      dst_last_o;
    logic                      done_o;
    logic                      busy_o;

    modport slave (
        input  src_valid_i, rw_i, l2_addr_i, ext_addr_i, size_i, trans_id_i,
               ext_act_i, l2_act_i, ext_count_i, l2_count_i, ext_stride_i,
               l2_stride_i, abort_i, dst_ready_i,
        output src_ready_o, dst_valid_o, dst_rw_o, dst_l2_addr_o, dst_ext_addr_o,
               dst_size_o, dst_trans_id_o, dst_last_o, done_o, busy_o
    );

    modport master (
        output src_valid_i, rw_i, l2_addr_i, ext_addr_i, size_i, trans_id_i,
               ext_act_i, l2_act_i, ext_count_i, l2_count_i, ext_stride_i,
               l2_stride_i, abort_i, dst_ready_i,
        input  src_ready_o, dst_valid_o, dst_rw_o, dst_l2_addr_o, dst_ext_addr_o,
               dst_size_o, dst_trans_id_o, dst_last_o, done_o, busy_o
    );
endinterface

// File: rtl/hyper_twd_burst_splitter_row_tracker.sv
// Per-side address walker: tracks current address, start of the current row
// and bytes left in that row; inactive sides simply advance linearly.
module hyper_split_row_tracker #(
    parameter int AWIDTH     = 32,
    parameter int TRANS_SIZE = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_load,
    input  logic [AWIDTH-1:0]     i_load_addr,
    input  logic [TRANS_SIZE-1:0] i_load_count,
    input  logic                  i_act,
    input  logic [TRANS_SIZE-1:0] i_count,
    input  logic [TRANS_SIZE-1:0] i_stride,
    input  logic [TRANS_SIZE-1:0] i_chunk,
    input  logic                  i_advance,
    output logic [AWIDTH-1:0]     o_addr,
    output logic [TRANS_SIZE-1:0] o_row_rem
);
    logic [AWIDTH-1:0]     r_addr;
    logic [AWIDTH-1:0]     r_row_base;
    logic [TRANS_SIZE-1:0] r_row_rem;
    logic [AWIDTH-1:0]     w_next_row;
    logic                  w_row_end;

    // Stride is zero-extended (or truncated) to the address width; sums wrap.
    assign w_next_row = r_row_base + AWIDTH'(i_stride);
    assign w_row_end  = i_act && (i_chunk == r_row_rem);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr     <= '0;
            r_row_base <= '0;
            r_row_rem  <= '0;
        end else if (i_load) begin
            r_addr     <= i_load_addr;
            r_row_base <= i_load_addr;
            r_row_rem  <= i_load_count;
        end else if (i_advance) begin
            if (w_row_end) begin
                r_addr     <= w_next_row;
                r_row_base <= w_next_row;
                r_row_rem  <= i_count;
            end else begin
                r_addr    <= r_addr + AWIDTH'(i_chunk);
                r_row_rem <= r_row_rem - i_chunk;
            end
        end
    end

    assign o_addr    = r_addr;
    assign o_row_rem = r_row_rem;
endmodule

// File: rtl/hyper_twd_burst_splitter.sv
// Splits a 1D/2D uDMA request into hyperbus chunks bounded by total, row ends
// and (with HYPER_SPLIT_BURST_BOUND_EN) the 2^MAX_BURST_LOG2 ext boundary.
module hyper_twd_burst_splitter
    import hyper_splitter_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int EXT_AWIDTH     = 32,
    parameter int TRANS_SIZE     = 16,
    parameter int ID_WIDTH       = 1,
    parameter int MAX_BURST_LOG2 = 9
) (
    input logic clk_i,
    input logic rst_ni,
    hyper_twd_burst_splitter_if.slave bus
);
    split_state_e              r_state, w_state_next;
    logic                      r_done, w_done_next;
    logic                      r_rw;
    logic [ID_WIDTH-1:0]       r_id;
    logic [TRANS_SIZE-1:0]     r_rem_total;
    logic                      r_ext_act, r_l2_act;
    logic [TRANS_SIZE-1:0]     r_ext_count, r_l2_count;
    logic [TRANS_SIZE-1:0]     r_ext_stride, r_l2_stride;

    logic                      w_accept, w_dst_valid, w_dst_hs, w_last;
    logic [TRANS_SIZE-1:0]     w_chunk, w_ext_rem, w_l2_rem;
    logic [EXT_AWIDTH-1:0]     w_ext_addr;
    logic [L2_AWIDTH_NOAL-1:0] w_l2_addr;

    assign w_accept    = bus.src_valid_i && (r_state == ST_IDLE);
    assign w_dst_valid = (r_state == ST_SPLIT);
    assign w_dst_hs    = w_dst_valid && bus.dst_ready_i;

`ifdef HYPER_SPLIT_BURST_BOUND_EN
    localparam int BW = MAX_BURST_LOG2 + 1;
    localparam int CW = (BW > TRANS_SIZE) ? BW : TRANS_SIZE;
    logic [CW-1:0] w_bound;
    assign w_bound = (CW'(1) << MAX_BURST_LOG2) - CW'(w_ext_addr[MAX_BURST_LOG2-1:0]);
`else
    logic w_unused_burst;
    assign w_unused_burst = ^MAX_BURST_LOG2;
`endif

    // Chunk is derived only from registers, so it holds while dst is stalled.
    always_comb begin
        w_chunk = r_rem_total;
        if (r_ext_act && (w_ext_rem < w_chunk)) w_chunk = w_ext_rem;
        if (r_l2_act && (w_l2_rem < w_chunk))   w_chunk = w_l2_rem;
`ifdef HYPER_SPLIT_BURST_BOUND_EN
        if (w_bound < CW'(w_chunk)) w_chunk = TRANS_SIZE'(w_bound);
`endif
    end

    assign w_last = (w_chunk == r_rem_total);

    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latch).
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.src_valid_i) begin
                    if (bus.size_i == '0) w_done_next  = 1'b1;
                    else                  w_state_next = ST_SPLIT;
                end
            end
            ST_SPLIT: begin
                if (w_dst_hs && w_last) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end else if (bus.abort_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rw         <= 1'b0;
            r_id         <= '0;
            r_rem_total  <= '0;
            r_ext_act    <= 1'b0;
            r_l2_act     <= 1'b0;
            r_ext_count  <= '0;
            r_l2_count   <= '0;
            r_ext_stride <= '0;
            r_l2_stride  <= '0;
        end else if (w_accept) begin
            r_rw         <= bus.rw_i;
            r_id         <= bus.trans_id_i;
            r_rem_total  <= bus.size_i;
            r_ext_act    <= bus.ext_act_i && (bus.ext_count_i != '0);
            r_l2_act     <= bus.l2_act_i && (bus.l2_count_i != '0);
            r_ext_count  <= bus.ext_count_i;
            r_l2_count   <= bus.l2_count_i;
            r_ext_stride <= bus.ext_stride_i;
            r_l2_stride  <= bus.l2_stride_i;
        end else if (w_dst_hs) begin
            r_rem_total <= r_rem_total - w_chunk;
        end
    end

    hyper_split_row_tracker #(.AWIDTH(EXT_AWIDTH), .TRANS_SIZE(TRANS_SIZE)) u_ext_row (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_load      (w_accept),
        .i_load_addr (bus.ext_addr_i),
        .i_load_count(bus.ext_count_i),
        .i_act       (r_ext_act),
        .i_count     (r_ext_count),
        .i_stride    (r_ext_stride),
        .i_chunk     (w_chunk),
        .i_advance   (w_dst_hs),
        .o_addr      (w_ext_addr),
        .o_row_rem   (w_ext_rem)
    );

    hyper_split_row_tracker #(.AWIDTH(L2_AWIDTH_NOAL), .TRANS_SIZE(TRANS_SIZE)) u_l2_row (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_load      (w_accept),
        .i_load_addr (bus.l2_addr_i),
        .i_load_count(bus.l2_count_i),
        .i_act       (r_l2_act),
        .i_count     (r_l2_count),
        .i_stride    (r_l2_stride),
        .i_chunk     (w_chunk),
        .i_advance   (w_dst_hs),
        .o_addr      (w_l2_addr),
        .o_row_rem   (w_l2_rem)
    );

    assign bus.src_ready_o    = (r_state == ST_IDLE);
    assign bus.dst_valid_o    = w_dst_valid;
    assign bus.dst_rw_o       = r_rw;
    assign bus.dst_l2_addr_o  = w_l2_addr;
    assign bus.dst_ext_addr_o = w_ext_addr;
    assign bus.dst_size_o     = w_chunk;
    assign bus.dst_trans_id_o = (r_state == ST_IDLE) ? {1'b1, {ID_WIDTH{1'b0}}} : {1'b0, r_id};
    assign bus.dst_last_o     = w_last;
    assign bus.done_o         = r_done;
    assign bus.busy_o         = (r_state != ST_IDLE);
endmodule

// File: doc/hyper_twd_burst_splitter.md
Name: hyper_twd_burst_splitter

Overview:
- Generalised successor of the 2D transfer splitter in the udma_hyper path; sits between the uDMA channel config and the hyperbus transaction FSM.
- Splits one 1D/2D request into chunks; each chunk is the minimum of four limits: remaining total, remaining ext row, remaining L2 row, and bytes to the next 2^MAX_BURST_LOG2 ext-address boundary.
- Unlike its predecessor, ext and L2 rows may have different counts, rows may be split across chunks, back-to-back chunks carry no SETUP bubble, and the block supports abort and a last-chunk flag.

Parameters:
- L2_AWIDTH_NOAL, 12, L2 address width
- EXT_AWIDTH, 32, hyperbus address width
- TRANS_SIZE, 16, size/count/stride width
- ID_WIDTH, 1, transaction ID width
- MAX_BURST_LOG2, 9, log2 of the ext burst boundary in bytes (only used with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- src_valid_i  in  1  request valid
- src_ready_o  out  1  request ready
- rw_i  in  1  1 = read (ext->L2), 0 = write
- l2_addr_i  in  L2_AWIDTH_NOAL  L2 start address
- ext_addr_i  in  EXT_AWIDTH  hyperbus start address
- size_i  in  TRANS_SIZE  total bytes
- trans_id_i  in  ID_WIDTH  transaction ID
- ext_act_i / l2_act_i  in  1 each  2D enable per side
- ext_count_i / l2_count_i  in  TRANS_SIZE each  row length
- ext_stride_i / l2_stride_i  in  TRANS_SIZE each  row-to-row stride
- abort_i  in  1  flush current request
- dst_valid_o  out  1  chunk valid
- dst_ready_i  in  1  chunk ready
- dst_rw_o  out  1  registered rw
- dst_l2_addr_o  out  L2_AWIDTH_NOAL  chunk L2 address
- dst_ext_addr_o  out  EXT_AWIDTH  chunk ext address
- dst_size_o  out  TRANS_SIZE  chunk length
- dst_trans_id_o  out  ID_WIDTH+1  {idle_flag, id}
- dst_last_o  out  1  final chunk of request
- done_o  out  1  one-cycle pulse at request completion
- busy_o  out  1  state != IDLE

Behaviour:
- Reset values: src_ready_o=1, dst_valid_o=0, done_o=0, busy_o=0, dst_trans_id_o=1<<ID_WIDTH; all address/size/row registers 0.
- States are IDLE and SPLIT.
- IDLE: src_ready_o=1. On handshake, register all inputs; load the row-remainder counters with the counts; go to SPLIT. dst_valid_o goes high the next cycle (latency 1). dst_trans_id_o={0,trans_id_i}.
- size_i==0: accepted, no chunk emitted, done_o pulses next cycle, state stays IDLE.
- act=1 with count==0: treated as act=0 for that side.
- Chunk = min(rem_total, ext_row_rem if ext active, l2_row_rem if l2 active, boundary term); combinational from registers.
- On dst handshake, for each active side:
  - if chunk == row_rem: addr = row_base + stride, row_base updated to the same value, row_rem = count;
  - else: addr += chunk, row_rem -= chunk.
- On dst handshake, for each inactive side: addr += chunk.
- On dst handshake: rem_total -= chunk.
- dst_valid_o stays high across consecutive chunks; new chunk values appear the cycle after the handshake.
- While valid && !ready, every dst_* output holds stable.
- dst_last_o = (chunk == rem_total).
- Last-chunk handshake: the next cycle is IDLE, done_o pulses, dst_trans_id_o returns to 1<<ID_WIDTH, src_ready_o=1. This gives one bubble between requests.
- Addresses wrap modulo their width; strides are zero-extended.
- abort_i in SPLIT: next cycle IDLE, dst_valid_o=0, no done_o. A handshake in the same cycle counts as delivered. abort_i in IDLE is ignored.
- Reset mid-operation: all outputs return to reset values immediately.

Optional Feature:
- HYPER_SPLIT_BURST_BOUND_EN defined: boundary term = 2^MAX_BURST_LOG2 - ext_addr[MAX_BURST_LOG2-1:0]. No chunk crosses the boundary.
- Not defined: boundary term is omitted and MAX_BURST_LOG2 is unused.

Decomposition:
- hyper_splitter_pkg holds: the state enum, a chunk_req_t struct (addrs, size, rw, id, last), and IDLE_ID = 1<<ID_WIDTH.
- One sub-module, hyper_split_row_tracker, instantiated twice (ext, L2): holds addr, row_base and row_rem; inputs act/count/stride/chunk/advance.

Test Plan:
- 1D, rw=1, size 64, no act, ext 0x0, feature off, dst_ready=1 -> one chunk {ext 0x0, size 64, last=1}; done_o pulses 2 cycles after src handshake.
- ext_act: size 24, ext_count 8, ext_stride 0x100, ext 0x1000, l2 0x10 -> chunks (0x1000,0x10,8), (0x1100,0x18,8), (0x1200,0x20,8,last).
- Both sides active: ext_count 8/stride 0x100, l2_count 12/stride 0x40, size 24, ext 0x1000, l2 0x0 -> sizes 8,4,4,8 at (0x1000,0x00), (0x1100,0x08), (0x1104,0x40), (0x1200,0x44,last).
- Feature on, MAX_BURST_LOG2=9, size 100, ext 0x1F0 -> chunks 16 @0x1F0, 84 @0x200.
- dst_ready_i low for 5 cycles mid-transfer -> dst_* outputs held constant; abort_i pulse during chunk 2 of 3 -> dst_valid_o=0 next cycle, no done_o, src_ready_o=1.
- size 0 -> no dst_valid_o, done_o pulse; async reset asserted in SPLIT -> dst_valid_o=0 and trans_id=IDLE_ID immediately.
